// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding and bubble instruction.
// No logic; types and constants only.
// Imported by hazard_ctrl and its sub-modules.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_REDIRECT  = 2'd1,
        ST_IMEM_WAIT = 2'd2
    } hazard_state_t;

    localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

endpackage

// File: rtl/hazard_perf_cnt.sv
// Saturating performance counters for PC-stall cycles and taken-branch flush events.
// Latency: counts visible one clk after the qualifying cycle.
// Backpressure: none; counters stick at all-ones instead of wrapping.
module hazard_perf_cnt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_inc,
    input  logic        flush_inc,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_events
);

    logic [31:0] stall_q;
    logic [31:0] flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_inc && (stall_q != '1)) stall_q <= stall_q + 32'd1;
            if (flush_inc && (flush_q != '1)) flush_q <= flush_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
    assign flush_events = flush_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, branch squash, imem wait and dmem freeze (perf counters under HAZARD_PERF_CNT_EN).
// Latency: stall/flush outputs are combinational from inputs and current state; state/counters update on clk.
// Backpressure: dmem_busy_i freezes every stage and all internal state; outputs forced low while rst_n is low.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int BRANCH_FLUSH_CYCLES = 1,
    parameter int IMEM_TIMEOUT        = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_uses_rs1_i,
    input  logic        id_uses_rs2_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        ex_mem_read_i,
    input  logic        ex_branch_taken_i,
    input  logic        imem_ready_i,
    input  logic        dmem_busy_i,
    output logic        pc_stall_o,
    output logic        if_id_stall_o,
    output logic        if_id_flush_o,
    output logic        id_ex_stall_o,
    output logic        id_ex_flush_o,
    output logic        ex_mem_stall_o,
    output logic [1:0]  state_o,
    output logic        imem_timeout_o,
    output logic [31:0] stall_cycles_o,
    output logic [31:0] flush_events_o
);

    localparam logic [2:0]  FLUSH_LOAD = 3'(BRANCH_FLUSH_CYCLES);
    localparam logic [15:0] TO_LIMIT   = 16'(IMEM_TIMEOUT);

    hazard_state_t state_q, state_d;
    logic [2:0]    redir_q, redir_d;
    logic [15:0]   to_cnt_q, to_cnt_d;
    logic          to_flag_q, to_flag_d;
    logic          to_hit;
    logic          load_use;
    logic          pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall;

    assign load_use = ex_mem_read_i && (ex_rd_i != 5'd0) &&
                      ((id_uses_rs1_i && (id_rs1_i == ex_rd_i)) ||
                       (id_uses_rs2_i && (id_rs2_i == ex_rd_i)));

    always_comb begin
        pc_stall     = 1'b0;
        if_id_stall  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_stall  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_stall = 1'b0;
        state_d      = state_q;
        redir_d      = redir_q;
        to_cnt_d     = to_cnt_q;
        to_flag_d    = to_flag_q;
        to_hit       = 1'b0;

        if (dmem_busy_i) begin
            pc_stall     = 1'b1;
            if_id_stall  = 1'b1;
            id_ex_stall  = 1'b1;
            ex_mem_stall = 1'b1;
        end else begin
            // Timeout flag asserts in the cycle the low streak reaches the limit.
            if (imem_ready_i) begin
                to_cnt_d = '0;
            end else begin
                if (to_cnt_q != TO_LIMIT) to_cnt_d = to_cnt_q + 16'd1;
                if (to_cnt_q >= TO_LIMIT - 16'd1) to_hit = 1'b1;
            end
            to_flag_d = to_flag_q | to_hit;

            if (state_q == ST_IMEM_WAIT && imem_ready_i) state_d = ST_RUN;

            if (ex_branch_taken_i) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                if (FLUSH_LOAD != 3'd0) begin
                    state_d = ST_REDIRECT;
                    redir_d = FLUSH_LOAD;
                end else begin
                    state_d = ST_RUN;
                    redir_d = '0;
                end
            end else if (load_use) begin
                pc_stall    = 1'b1;
                if_id_stall = 1'b1;
                id_ex_flush = 1'b1;
            end else if (state_q == ST_REDIRECT) begin
                if_id_flush = 1'b1;
                if (imem_ready_i) begin
                    redir_d = redir_q - 3'd1;
                    if (redir_q <= 3'd1) state_d = ST_RUN;
                end
            end else if (!imem_ready_i) begin
                pc_stall    = 1'b1;
                if_id_flush = 1'b1;
                state_d     = ST_IMEM_WAIT;
            end else begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RUN;
            redir_q   <= '0;
            to_cnt_q  <= '0;
            to_flag_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            redir_q   <= redir_d;
            to_cnt_q  <= to_cnt_d;
            to_flag_q <= to_flag_d;
        end
    end

    // Reset must silence the combinational controls too, not just the flops.
    assign pc_stall_o     = rst_n & pc_stall;
    assign if_id_stall_o  = rst_n & if_id_stall;
    assign if_id_flush_o  = rst_n & if_id_flush;
    assign id_ex_stall_o  = rst_n & id_ex_stall;
    assign id_ex_flush_o  = rst_n & id_ex_flush;
    assign ex_mem_stall_o = rst_n & ex_mem_stall;
    assign imem_timeout_o = rst_n & (to_flag_q | to_hit);
    assign state_o        = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic flush_evt;
    assign flush_evt = rst_n & ~dmem_busy_i & ex_branch_taken_i;

    hazard_perf_cnt u_perf (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall_inc    (pc_stall_o),
        .flush_inc    (flush_evt),
        .stall_cycles (stall_cycles_o),
        .flush_events (flush_events_o)
    );
`else
    assign stall_cycles_o = '0;
    assign flush_events_o = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with IMEM_TIMEOUT=4 and BRANCH_FLUSH_CYCLES=1.
// Control vector order: {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall}.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_branch_taken, imem_ready, dmem_busy;
    logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall;
    logic [1:0]  state;
    logic        imem_timeout;
    logic [31:0] stall_cycles, flush_events;
    logic [5:0]  ctl;

    int total = 0;
    int bad   = 0;

    localparam logic [5:0] C_NONE   = 6'b000000;
    localparam logic [5:0] C_LDUSE  = 6'b110010;
    localparam logic [5:0] C_BRANCH = 6'b001010;
    localparam logic [5:0] C_REDIR  = 6'b001000;
    localparam logic [5:0] C_BUSY   = 6'b110101;
    localparam logic [5:0] C_IWAIT  = 6'b101000;

    always #5 clk = ~clk;

    assign ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall};

    hazard_ctrl #(.BRANCH_FLUSH_CYCLES(1), .IMEM_TIMEOUT(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .id_rs1_i          (id_rs1),
        .id_rs2_i          (id_rs2),
        .id_uses_rs1_i     (id_uses_rs1),
        .id_uses_rs2_i     (id_uses_rs2),
        .ex_rd_i           (ex_rd),
        .ex_mem_read_i     (ex_mem_read),
        .ex_branch_taken_i (ex_branch_taken),
        .imem_ready_i      (imem_ready),
        .dmem_busy_i       (dmem_busy),
        .pc_stall_o        (pc_stall),
        .if_id_stall_o     (if_id_stall),
        .if_id_flush_o     (if_id_flush),
        .id_ex_stall_o     (id_ex_stall),
        .id_ex_flush_o     (id_ex_flush),
        .ex_mem_stall_o    (ex_mem_stall),
        .state_o           (state),
        .imem_timeout_o    (imem_timeout),
        .stall_cycles_o    (stall_cycles),
        .flush_events_o    (flush_events)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_branch_taken = 1'b0; imem_ready = 1'b1; dmem_busy = 1'b0;
    endtask

    task automatic load_use_x5();
        ex_mem_read = 1'b1; ex_rd = 5'd5;
        id_rs1 = 5'd3; id_uses_rs1 = 1'b1;
        id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
    endtask

    // Advance to 2 time units after the next rising edge; comb outputs settled.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        dmem_busy = 1'b1;
        #3;
        chk("rst_ctl", 32'(ctl), 32'(C_NONE));
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_timeout", 32'(imem_timeout), 32'd0);
        chk("rst_stall_cnt", stall_cycles, 32'd0);
        chk("rst_flush_cnt", flush_events, 32'd0);
        dmem_busy = 1'b0;
        #4 rst_n = 1'b1;
        tick();
        chk("idle_ctl", 32'(ctl), 32'(C_NONE));

        load_use_x5();
        #1 chk("lduse_ctl", 32'(ctl), 32'(C_LDUSE));
        chk("lduse_state", 32'(state), 32'd0);
        tick();
        ex_mem_read = 1'b0; ex_rd = 5'd0;
        #1 chk("lduse_resume", 32'(ctl), 32'(C_NONE));

        idle();
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1;
        #1 chk("x0_nostall", 32'(ctl), 32'(C_NONE));
        ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b0;
        #1 chk("unused_rs1", 32'(ctl), 32'(C_NONE));

        tick();
        idle();
        ex_branch_taken = 1'b1;
        #1 chk("br_n_ctl", 32'(ctl), 32'(C_BRANCH));
        tick();
        ex_branch_taken = 1'b0;
        #1 chk("br_n1_ctl", 32'(ctl), 32'(C_REDIR));
        chk("br_n1_state", 32'(state), 32'd1);
        tick();
        chk("br_n2_state", 32'(state), 32'd0);
        chk("br_n2_ctl", 32'(ctl), 32'(C_NONE));

        ex_branch_taken = 1'b1;
        tick();
        ex_branch_taken = 1'b0; imem_ready = 1'b0;
        #1 chk("brw_ctl", 32'(ctl), 32'(C_REDIR));
        tick();
        chk("brw_hold_state", 32'(state), 32'd1);
        imem_ready = 1'b1;
        #1 chk("brw_ready_ctl", 32'(ctl), 32'(C_REDIR));
        tick();
        chk("brw_run_state", 32'(state), 32'd0);

        dmem_busy = 1'b1; ex_branch_taken = 1'b1; load_use_x5();
        #1 chk("busy_ctl", 32'(ctl), 32'(C_BUSY));
        tick();
        chk("busy_frozen_state", 32'(state), 32'd0);
        chk("busy_hold_ctl", 32'(ctl), 32'(C_BUSY));
        dmem_busy = 1'b0;
        #1 chk("busy_release_br", 32'(ctl), 32'(C_BRANCH));
        tick();
        idle();
        #1 chk("busy_redirect", 32'(state), 32'd1);
        tick();
        chk("busy_run", 32'(state), 32'd0);

        imem_ready = 1'b0;
        #1 chk("to_c1_ctl", 32'(ctl), 32'(C_IWAIT));
        chk("to_c1_flag", 32'(imem_timeout), 32'd0);
        tick();
        chk("to_c2_state", 32'(state), 32'd2);
        chk("to_c2_flag", 32'(imem_timeout), 32'd0);
        tick();
        chk("to_c3_flag", 32'(imem_timeout), 32'd0);
        tick();
        chk("to_c4_flag", 32'(imem_timeout), 32'd1);
        tick();
        imem_ready = 1'b1;
        #1 chk("to_sticky_a", 32'(imem_timeout), 32'd1);
        chk("to_ready_ctl", 32'(ctl), 32'(C_NONE));
        tick();
        chk("to_back_run", 32'(state), 32'd0);
        chk("to_sticky_b", 32'(imem_timeout), 32'd1);

        ex_branch_taken = 1'b1;
        tick();
        ex_branch_taken = 1'b0;
        dmem_busy = 1'b1;
        #1 chk("pre_rst_state", 32'(state), 32'd1);
        rst_n = 1'b0;
        #1 chk("arst_state", 32'(state), 32'd0);
        chk("arst_ctl", 32'(ctl), 32'(C_NONE));
        chk("arst_timeout", 32'(imem_timeout), 32'd0);
        chk("arst_stall_cnt", stall_cycles, 32'd0);
        chk("arst_flush_cnt", flush_events, 32'd0);
        idle();
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst_state", 32'(state), 32'd0);

`ifdef HAZARD_PERF_CNT_EN
        load_use_x5();
        tick();
        tick();
        idle();
        chk("perf_stall2", stall_cycles, 32'd2);
        ex_branch_taken = 1'b1;
        tick();
        ex_branch_taken = 1'b0;
        tick();
        chk("perf_flush1", flush_events, 32'd1);
        chk("perf_stall_kept", stall_cycles, 32'd2);
        dut.u_perf.stall_q = 32'hFFFF_FFFE;
        dut.u_perf.flush_q = 32'hFFFF_FFFE;
        imem_ready = 1'b0;
        tick();
        chk("perf_stall_max", stall_cycles, 32'hFFFF_FFFF);
        tick();
        tick();
        chk("perf_stall_sat", stall_cycles, 32'hFFFF_FFFF);
        imem_ready = 1'b1;
        tick();
        ex_branch_taken = 1'b1;
        tick();
        chk("perf_flush_max", flush_events, 32'hFFFF_FFFF);
        tick();
        chk("perf_flush_sat", flush_events, 32'hFFFF_FFFF);
        idle();
`else
        load_use_x5();
        tick();
        ex_branch_taken = 1'b1;
        tick();
        idle();
        chk("noperf_stall", stall_cycles, 32'd0);
        chk("noperf_flush", flush_events, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
